// File: rtl/sclk_burst_arb_pkg.sv
// sclk_burst_arb_pkg
//  Shared definitions for the serial-clock burst arbiter and the peripheral
//  engines that use it.
//  - arb_state_t      : FSM encoding IDLE=0, RUN=1, GAP=2
//  - ARB_DIV_DEFAULT  : reset half-period terminal count (250 cycles)
//  - ARB_LEN_W        : width of a per-requester burst length
//  - ptr_w()          : width of a requester index for n requesters
package sclk_burst_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int ARB_DIV_W       = 8;
    localparam int ARB_DIV_DEFAULT = 249;
    localparam int ARB_LEN_W       = 8;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sclk_rr_arbiter.sv
// sclk_rr_arbiter
//  Combinational round-robin pick: first set request scanning upward from
//  i_ptr with wrap-around.
//  Ports:
//   i_req  in  NREQ   request levels
//   i_ptr  in  PTR_W  index the scan starts from
//   o_win  out NREQ   one-hot winner (0 when no request)
//   o_idx  out PTR_W  index of the winner
//   o_any  out 1      at least one request pending
module sclk_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_win,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic w_found;
    int   w_pos;

    always_comb begin
        o_win   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = (int'(i_ptr) + k) % NREQ;
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_win[w_pos] = 1'b1;
                o_idx        = PTR_W'(w_pos);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/sclk_burst_arb.sv
// sclk_burst_arb
//  Shares one slow serial-clock generator among NREQ requesters. Round-robin
//  grants each requester a burst of req_len sclk periods, then enforces a
//  low gap of one half-period before the next burst.
//  Optional feature macro: SCLK_STRETCH_EN (adds sclk_hold, which stretches
//  the high phase while asserted at the high terminal count).
//  Ports:
//   clk_50mhz  in   system clock
//   rst_n      in   async active-low reset
//   req        in   NREQ request levels
//   req_len    in   NREQ*LEN_W burst lengths, slice i for requester i
//   div_load   in   load div_val as terminal count (IDLE only)
//   div_val    in   terminal count, half-period = div_val+1 cycles
//   sclk_hold  in   (SCLK_STRETCH_EN only) stretch the current high phase
//   grant      out  one-hot burst owner
//   busy       out  high outside IDLE
//   sclk       out  generated slow clock, idles low
//   sclk_rise  out  strobe in the cycle sclk becomes 1
//   sclk_fall  out  strobe in the cycle sclk becomes 0
//   done       out  one-cycle pulse to the owner at burst end
module sclk_burst_arb
    import sclk_burst_arb_pkg::*;
#(
    parameter int               NREQ        = 4,
    parameter int               DIV_W       = ARB_DIV_W,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(ARB_DIV_DEFAULT),
    parameter int               LEN_W       = ARB_LEN_W
) (
    input  logic                  clk_50mhz,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic                  div_load,
    input  logic [DIV_W-1:0]      div_val,
`ifdef SCLK_STRETCH_EN
    input  logic                  sclk_hold,
`endif
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  sclk,
    output logic                  sclk_rise,
    output logic                  sclk_fall,
    output logic [NREQ-1:0]       done
);

    localparam int PTR_W = ptr_w(NREQ);

    arb_state_t       r_state;
    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_rem;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  r_done;
    logic             r_busy;
    logic             r_sclk;
    logic             r_rise;
    logic             r_fall;

    logic [NREQ-1:0]  w_win;
    logic [PTR_W-1:0] w_win_idx;
    logic [PTR_W-1:0] w_next_ptr;
    logic             w_any;
    logic             w_tc;
    logic             w_hold;

    sclk_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req (req),
        .i_ptr (r_rr_ptr),
        .o_win (w_win),
        .o_idx (w_win_idx),
        .o_any (w_any)
    );

`ifdef SCLK_STRETCH_EN
    assign w_hold = sclk_hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_tc       = (r_cnt == r_div_q);
    assign w_next_ptr = (w_win_idx == PTR_W'(NREQ - 1)) ? '0 : w_win_idx + PTR_W'(1);

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_div_q  <= DIV_DEFAULT;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_sclk   <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    // divider reload wins over arbitration in the same cycle
                    if (div_load) begin
                        r_div_q <= div_val;
                    end else if (w_any) begin
                        r_grant  <= w_win;
                        r_rem    <= req_len[int'(w_win_idx)*LEN_W +: LEN_W];
                        r_cnt    <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // rem can only be 0 here right after a zero-length grant;
                    // the last fall of a real burst leaves RUN directly
                    if (r_rem == '0) begin
                        r_done  <= r_grant;
                        r_grant <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end else if (w_tc) begin
                        // a hold at the high terminal count freezes cnt and
                        // postpones the fall
                        if (!(r_sclk && w_hold)) begin
                            r_cnt  <= '0;
                            r_sclk <= ~r_sclk;
                            r_rise <= ~r_sclk;
                            r_fall <= r_sclk;
                            if (r_sclk) begin
                                r_rem <= r_rem - LEN_W'(1);
                                if (r_rem == LEN_W'(1)) begin
                                    r_done  <= r_grant;
                                    r_grant <= '0;
                                    r_state <= ST_GAP;
                                end
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (w_tc) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign sclk      = r_sclk;
    assign sclk_rise = r_rise;
    assign sclk_fall = r_fall;
    assign done      = r_done;

endmodule

// File: tb/tb_sclk_burst_arb.sv
// tb_sclk_burst_arb
//  Directed scenarios plus randomized traffic against a schedule-based model:
//  a burst granted at edge g with length L and half-period H is fully
//  described by offsets from g (rises at odd multiples of H, falls at even
//  multiples, done at 2HL, idle again at 2HL+H).
//  With SCLK_STRETCH_EN defined, a final scenario exercises sclk_hold.
module tb_sclk_burst_arb;

    localparam int NREQ  = 4;
    localparam int DIV_W = 8;
    localparam int LEN_W = 8;

    logic                  clk_50mhz = 1'b0;
    logic                  rst_n     = 1'b1;
    logic [NREQ-1:0]       req       = '0;
    logic [NREQ*LEN_W-1:0] req_len   = '0;
    logic                  div_load  = 1'b0;
    logic [DIV_W-1:0]      div_val   = '0;
`ifdef SCLK_STRETCH_EN
    logic                  sclk_hold = 1'b0;
`endif
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  sclk;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic [NREQ-1:0]       done;

    always #10 clk_50mhz = ~clk_50mhz;

    sclk_burst_arb dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .req       (req),
        .req_len   (req_len),
        .div_load  (div_load),
        .div_val   (div_val),
`ifdef SCLK_STRETCH_EN
        .sclk_hold (sclk_hold),
`endif
        .grant     (grant),
        .busy      (busy),
        .sclk      (sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .done      (done)
    );

    int checks   = 0;
    int failures = 0;

    // model state
    int e        = 0;
    bit m_active = 0;
    bit m_en     = 1;
    int m_g, m_L, m_H, m_own;
    int m_div    = 249;
    int m_rr     = 0;

    // observed event logs (edge numbers)
    int ev_rise[$], ev_fall[$], ev_done[$], ev_done_vec[$];
    int gnt_edge[$], gnt_own[$], gnt_vec[$], busy_low[$];
    logic [NREQ-1:0] prev_grant = '0;
    logic            prev_busy  = 1'b0;

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, $signed(act), $signed(exp), e);
            if (failures >= 40) begin
                summary();
                $finish;
            end
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++)
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic int end_off();
        return (m_L > 0) ? 2 * m_H * m_L + m_H : 1 + m_H;
    endfunction

    task automatic clr_logs();
        ev_rise.delete(); ev_fall.delete(); ev_done.delete(); ev_done_vec.delete();
        gnt_edge.delete(); gnt_own.delete(); gnt_vec.delete(); busy_low.delete();
    endtask

    // one clock: advance the model with the inputs the DUT sees at the edge,
    // then compare after the edge
    task automatic step();
        int en, d, t, ph;
        logic [NREQ-1:0] xg, xd;
        logic xb, xs, xr, xf;
        en = e + 1;
        if (!m_active) begin
            if (div_load) m_div = int'(div_val);
            else if (req != '0) begin
                m_own    = pick(req, m_rr);
                m_g      = en;
                m_L      = int'(req_len[m_own*LEN_W +: LEN_W]);
                m_H      = m_div + 1;
                m_active = 1;
                m_rr     = (m_own + 1) % NREQ;
            end
        end else if (en - m_g == end_off()) begin
            m_active = 0;
        end
        @(posedge clk_50mhz);
        #1;
        e  = en;
        xg = '0; xd = '0; xb = 0; xs = 0; xr = 0; xf = 0;
        if (m_active) begin
            d  = e - m_g;
            t  = 2 * m_H * m_L;
            xb = 1;
            if (m_L == 0) begin
                if (d == 0) xg[m_own] = 1'b1;
                if (d == 1) xd[m_own] = 1'b1;
            end else begin
                ph = d / m_H;
                if (d < t) xg[m_own] = 1'b1;
                if (d == t) xd[m_own] = 1'b1;
                if (d < t && ph % 2 == 1) begin
                    xs = 1;
                    if (d % m_H == 0) xr = 1;
                end
                if (d > 0 && d <= t && d % m_H == 0 && ph % 2 == 0) xf = 1;
            end
        end
        if (m_en) begin
            chk("grant", 32'(grant), 32'(xg));
            chk("busy", 32'(busy), 32'(xb));
            chk("sclk", 32'(sclk), 32'(xs));
            chk("sclk_rise", 32'(sclk_rise), 32'(xr));
            chk("sclk_fall", 32'(sclk_fall), 32'(xf));
            chk("done", 32'(done), 32'(xd));
        end
        if (grant != '0 && grant != prev_grant) begin
            gnt_edge.push_back(e);
            gnt_own.push_back(oh_idx(grant));
            gnt_vec.push_back(int'(grant));
        end
        if (sclk_rise) ev_rise.push_back(e);
        if (sclk_fall) ev_fall.push_back(e);
        if (done != '0) begin
            ev_done.push_back(e);
            ev_done_vec.push_back(int'(done));
        end
        if (prev_busy && !busy) busy_low.push_back(e);
        prev_grant = grant;
        prev_busy  = busy;
    endtask

    task automatic reset_dut(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_grant"}, 32'(grant), 0);
        chk({tag, "_rst_busy"}, 32'(busy), 0);
        chk({tag, "_rst_sclk"}, 32'({sclk, sclk_rise, sclk_fall}), 0);
        chk({tag, "_rst_done"}, 32'(done), 0);
        m_active = 0; m_div = 249; m_rr = 0;
        prev_grant = '0; prev_busy = 1'b0;
        repeat (2) @(posedge clk_50mhz);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit && busy_low.size() == 0; i++) step();
        chk({tag, "_timeout"}, 32'(busy_low.size() > 0), 1);
    endtask

    initial begin
        int g;
        #3;
        reset_dut("init");
        repeat (3) step();

        // 1: single burst, len 2, default divider
        clr_logs();
        req_len[7:0] = 8'd2; req = 4'b0001;
        step();
        req = '0;
        wait_idle("t1", 1400);
        g = qget(gnt_edge, 0);
        chk("t1_grant_vec", qget(gnt_vec, 0), 1);
        chk("t1_rise_n", ev_rise.size(), 2);
        chk("t1_rise0", qget(ev_rise, 0) - g, 250);
        chk("t1_rise1", qget(ev_rise, 1) - g, 750);
        chk("t1_fall0", qget(ev_fall, 0) - g, 500);
        chk("t1_fall1", qget(ev_fall, 1) - g, 1000);
        chk("t1_done", qget(ev_done, 0) - g, 1000);
        chk("t1_done_vec", qget(ev_done_vec, 0), 1);
        chk("t1_busy_low", qget(busy_low, 0) - g, 1250);

        // 2: all request, len 1 each, rr wrap; each burst spans 3*250+1 edges
        reset_dut("t2");
        clr_logs();
        req_len = {4{8'd1}}; req = 4'b1111;
        for (int i = 0; i < 5000 && gnt_edge.size() < 5; i++) step();
        req = '0;
        chk("t2_timeout", 32'(gnt_edge.size() >= 5), 1);
        busy_low.delete();
        wait_idle("t2_drain", 1000);
        for (int i = 0; i < 5; i++) chk("t2_order", qget(gnt_own, i), i % 4);
        for (int i = 1; i < 5; i++) chk("t2_spacing", qget(gnt_edge, i) - qget(gnt_edge, i - 1), 751);

        // 3: divider 4 loaded in IDLE, requester 2 len 3
        clr_logs();
        div_val = 8'h04; div_load = 1'b1;
        step();
        div_load = 1'b0;
        req = 4'b0100; req_len[23:16] = 8'd3;
        step();
        req = '0;
        wait_idle("t3", 200);
        g = qget(gnt_edge, 0);
        chk("t3_own", qget(gnt_own, 0), 2);
        chk("t3_rise_n", ev_rise.size(), 3);
        chk("t3_fall_n", ev_fall.size(), 3);
        chk("t3_first_rise", qget(ev_rise, 0) - g, 5);
        chk("t3_rise_gap0", qget(ev_rise, 1) - qget(ev_rise, 0), 10);
        chk("t3_rise_gap1", qget(ev_rise, 2) - qget(ev_rise, 1), 10);
        chk("t3_done", qget(ev_done, 0) - g, 30);

        // 4: div_load mid-RUN ignored, then reset mid-RUN
        clr_logs();
        req = 4'b0001; req_len[7:0] = 8'd5;
        step();
        req = '0;
        repeat (7) step();
        div_val = 8'h10; div_load = 1'b1;
        step();
        div_load = 1'b0;
        repeat (20) step();
        chk("t4_period", qget(ev_rise, 1) - qget(ev_rise, 0), 10);
        chk("t4_busy_mid", 32'(busy), 1);
        reset_dut("t4");
        clr_logs();
        req = 4'b0110; req_len[15:8] = 8'd0;
        step();
        req = '0;
        chk("t4_scan_from0", qget(gnt_own, 0), 1);
        wait_idle("t4", 400);

        // 5: zero-length burst on requester 1, default divider
        clr_logs();
        req = 4'b0010; req_len[15:8] = 8'd0;
        step();
        req = '0;
        wait_idle("t5", 400);
        g = qget(gnt_edge, 0);
        chk("t5_own", qget(gnt_own, 0), 1);
        chk("t5_no_edges", ev_rise.size() + ev_fall.size(), 0);
        chk("t5_done", qget(ev_done, 0) - g, 1);
        chk("t5_done_vec", qget(ev_done_vec, 0), 2);
        chk("t5_busy_low", qget(busy_low, 0) - g, 251);

        // randomized traffic, short dividers
        div_val = 8'd2; div_load = 1'b1;
        step();
        div_load = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = NREQ'($urandom_range(0, 15));
                for (int k = 0; k < NREQ; k++) req_len[k*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 3));
            end
            div_load = ($urandom_range(0, 19) == 0);
            div_val  = DIV_W'($urandom_range(0, 6));
            step();
        end
        req = '0; div_load = 1'b0;
        busy_low.delete();
        if (busy) wait_idle("rand_drain", 200);

`ifdef SCLK_STRETCH_EN
        // 6: hold for 37 cycles at the first high terminal count
        m_en = 0;
        reset_dut("t6");
        clr_logs();
        req = 4'b0001; req_len[7:0] = 8'd1;
        step();
        req = '0;
        g = e;
        for (int i = 0; i < 600 && e < g + 499; i++) step();
        sclk_hold = 1'b1;
        repeat (37) step();
        sclk_hold = 1'b0;
        for (int i = 0; i < 600 && ev_fall.size() == 0; i++) step();
        chk("t6_rise", qget(ev_rise, 0) - g, 250);
        chk("t6_high", qget(ev_fall, 0) - qget(ev_rise, 0), 287);
        busy_low.delete();
        wait_idle("t6", 1000);
`endif

        summary();
        $finish;
    end

endmodule
